lc4_vmem_scanner: RTL and testbench
===================================

// Module: lc4_vmem_scanner
// PURPOSE
//  Read-side initiator for the memory video port (vaddr/vout). Scans the LC4 frame buffer in raster
//  order, tolerates the fixed port read latency, and buffers the returned words in a small FIFO.
//  Pixels leave on a valid/ready stream tagged start-of-frame and end-of-line. Feeds the display
//  pipeline; the frame buffer is never written from this block.
// PARAMETERS
//  BASE_ADDR     16'hC000  word address of pixel (0,0)
//  FB_WIDTH      128       pixels per row
//  FB_HEIGHT     124       rows per frame
//  READ_LATENCY  1         cycles from vaddr presented to vout valid (1..4)
//  FIFO_DEPTH    8         pixel FIFO entries (power of 2, >= READ_LATENCY+1)
// PORTS
//  clk        in   1   single clock; the video port is driven from this clock
//  rst        in   1   reset, asynchronous, active-high
//  gwe        in   1   global write enable; when 0 no state changes (full freeze)
//  enable     in   1   1 = issue reads; 0 = stop issuing, in-flight reads still land
//  vaddr      out  16  frame-buffer word address to memory video port
//  vout       in   16  read data returned by memory
//  pix_data   out  16  pixel word at FIFO head
//  pix_valid  out  1   FIFO non-empty
//  pix_ready  in   1   consumer accepts head when pix_valid & pix_ready & gwe
//  pix_sof    out  1   head is pixel (0,0)
//  pix_eol    out  1   head is last pixel of its row (x == FB_WIDTH-1)
//  busy       out  1   reads in flight or FIFO non-empty
// BEHAVIOUR
//  Reset (async, rst=1): x=0, y=0, vaddr=BASE_ADDR, in-flight pipe cleared, FIFO empty;
//    pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, busy=0. Applies mid-frame/mid-read; late
//    vout data for pre-reset reads is discarded (pipe tags cleared).
//  All registers update only on clk edges where gwe=1; gwe=0 holds every output stable.
//  Issue rule (cycle t): issue = enable & (inflight + fifo_count < FIFO_DEPTH). Credit counts
//    reads not yet in FIFO, so the FIFO can never overflow regardless of pix_ready.
//  vaddr is a register = BASE_ADDR + y*FB_WIDTH + x (mod 2^16). On issue, the address held in
//    cycle t is the read; x/y advance and vaddr updates at end of cycle t.
//  Counters: x++ ; at x=FB_WIDTH-1 -> x=0,y++ ; at (FB_WIDTH-1,FB_HEIGHT-1) -> x=0,y=0 (frame wrap).
//  Tag pipe: READ_LATENCY-stage shift register of {valid,sof,eol} per issue. vout for a read
//    issued in cycle t is sampled at the edge ending cycle t+READ_LATENCY and pushed to FIFO.
//  FIFO: entries {sof,eol,data}; head drives pix_* combinationally from registers (no extra
//    latency). Simultaneous push & pop allowed at any count including full (pop frees, push fills)
//    and empty (push only; head valid next cycle). fifo_count stays in 0..FIFO_DEPTH.
//  enable 1->0 mid-row: issuing stops after current cycle; x/y retained; resume continues at
//    the next unread address (no pixel skipped or repeated).
//  Throughput: with pix_ready=1 steady-state one pixel per cycle; first pix_valid at cycle
//    READ_LATENCY+1 after first issue.
//  busy = |inflight | (fifo_count != 0).
// TESTING
//  T1 reset: rst=1 asynchronously mid-cycle -> vaddr=16'hC000, pix_valid=0, busy=0 immediately.
//  T2 stream: enable=1, pix_ready=1, vout=f(vaddr)=~vaddr -> pix_data sequence 16'h3FFF,16'h3FFE,...;
//     first pixel has pix_sof=1; one pixel/cycle after READ_LATENCY+1 cycles.
//  T3 backpressure: pix_ready=0 for 50 cycles -> exactly FIFO_DEPTH pixels held, vaddr stops at
//     16'hC008 (DEPTH=8), no data lost/duplicated after pix_ready=1 (scoreboard).
//  T4 row/frame wrap: pix_eol=1 exactly on addr 16'hC07F, 16'hC0FF; after 15872 pixels next
//     head is addr 16'hC000 with pix_sof=1; vaddr never reaches 16'hFE00.
//  T5 gwe=0 for 10 cycles mid-stream with pix_ready=1 -> all outputs frozen, no pixel consumed.
//  T6 rst asserted with 3 reads in flight (READ_LATENCY=3) -> no stale pixel appears after
//     release; first post-reset pixel is addr 16'hC000 with pix_sof=1.

Source files
------------

// File: rtl/lc4_vmem_scanner.sv
// lc4_vmem_scanner
//   Read-side initiator for the memory video port. Walks the LC4 frame buffer
//   in raster order, absorbs the fixed read latency with a tag pipe, and holds
//   the returned words in a small FIFO. Pixels leave on a valid/ready stream
//   tagged start-of-frame / end-of-line. Never writes the frame buffer.
//
// Ports
//   clk, rst        single clock; asynchronous active-high reset
//   gwe             global write enable; 0 freezes every register
//   enable          1 = issue reads; 0 = stop issuing (in-flight reads still land)
//   vaddr [15:0]    registered word address to the memory video port
//   vout  [15:0]    read data, valid READ_LATENCY cycles after its vaddr
//   pix_data[15:0]  FIFO head word (0 when empty)
//   pix_valid       FIFO non-empty
//   pix_ready       consumer takes the head when pix_valid & pix_ready & gwe
//   pix_sof         head is pixel (0,0)
//   pix_eol         head is the last pixel of its row
//   busy            reads in flight or FIFO non-empty
module lc4_vmem_scanner #(
  parameter logic [15:0] BASE_ADDR    = 16'hC000,
  parameter int          FB_WIDTH     = 128,
  parameter int          FB_HEIGHT    = 124,
  parameter int          READ_LATENCY = 1,   // 1..4
  parameter int          FIFO_DEPTH   = 8    // power of 2, >= READ_LATENCY+1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        enable,
  output logic [15:0] vaddr,
  input  logic [15:0] vout,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy
);

  localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  // wide enough for fifo_count + in-flight reads without overflow
  localparam int SW = CW + 3;
  localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] data;
  } pix_t;

  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [READ_LATENCY:1]  vld_pipe, sof_pipe, eol_pipe;
  pix_t                   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [SW-1:0]          inflight, credit_used;
  logic                   issue, push, pop;
  logic                   at_sof, row_end, frame_end;
  pix_t                   head;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= READ_LATENCY; i++)
      inflight = inflight + SW'(vld_pipe[i]);
  end

  // Credit covers reads already issued but not yet in the FIFO, so a push
  // always has a free slot even if the consumer stalls indefinitely.
  assign credit_used = inflight + SW'(fifo_count);
  assign issue       = enable && (credit_used < SW'(FIFO_DEPTH));
  assign push        = vld_pipe[READ_LATENCY];
  assign pop         = pix_valid && pix_ready;

  assign row_end   = (x == X_LAST);
  assign frame_end = row_end && (y == Y_LAST);
  assign at_sof    = (x == '0) && (y == '0);

  // Raster counters. Rows are contiguous in memory, so vaddr just steps by
  // one except at the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      vaddr <= BASE_ADDR;
    end else if (gwe && issue) begin
      if (frame_end) begin
        x     <= '0;
        y     <= '0;
        vaddr <= BASE_ADDR;
      end else begin
        vaddr <= vaddr + 16'd1;
        if (row_end) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  // Tag pipe: one stage per cycle of read latency. Clearing it on reset drops
  // any data that returns for reads issued before the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eol_pipe <= '0;
    end else if (gwe) begin
      vld_pipe[1] <= issue;
      sof_pipe[1] <= issue && at_sof;
      eol_pipe[1] <= issue && row_end;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sof_pipe[i] <= sof_pipe[i-1];
        eol_pipe[i] <= eol_pipe[i-1];
      end
    end
  end

  // FIFO storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (gwe && push)
      fifo_mem[wr_ptr] <= {sof_pipe[READ_LATENCY], eol_pipe[READ_LATENCY], vout};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (gwe) begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign pix_valid = (fifo_count != '0);
  assign pix_data  = pix_valid ? head.data : 16'h0000;
  assign pix_sof   = pix_valid && head.sof;
  assign pix_eol   = pix_valid && head.eol;
  assign busy      = (|vld_pipe) || pix_valid;

endmodule

// File: tb/tb_lc4_vmem_scanner.sv
// Bench for lc4_vmem_scanner (READ_LATENCY=3, FIFO_DEPTH=8). The memory model
// returns ~address after the read latency; the reference model says pixel k
// since reset is address BASE + (k mod frame size).
module tb_lc4_vmem_scanner;
  localparam int RL    = 3;
  localparam int DEPTH = 8;
  localparam int W     = 128;
  localparam int H     = 124;
  localparam int FRAME = W * H;
  localparam logic [15:0] BASE = 16'hC000;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] data;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        gwe = 1'b1;
  logic        enable = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] vaddr, vout, pix_data;
  logic        pix_valid, pix_sof, pix_eol, busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t acc_q[$];
  int   exp_k = 0;          // pixels already checked since last reset
  logic [15:0] vq [RL];
  logic addr_oob = 1'b0;

  always #5 clk = ~clk;

  lc4_vmem_scanner #(
    .BASE_ADDR(BASE), .FB_WIDTH(W), .FB_HEIGHT(H),
    .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .gwe(gwe), .enable(enable),
    .vaddr(vaddr), .vout(vout),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy)
  );

  // Memory video port: same clock and write enable as the scanner.
  always @(posedge clk) begin
    if (gwe) begin
      vq[0] <= vaddr;
      for (int i = 1; i < RL; i++) vq[i] <= vq[i-1];
    end
  end
  assign vout = ~vq[RL-1];

  // Records completed handshakes; outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (gwe && pix_valid && pix_ready) acc_q.push_back({pix_sof, pix_eol, pix_data});
      if (int'(vaddr) < int'(BASE) || int'(vaddr) >= int'(BASE) + FRAME) addr_oob <= 1'b1;
    end
  end

  function automatic pix_t exp_pix(input int k);
    int p;
    logic [15:0] a;
    p = k % FRAME;
    a = BASE + 16'(p);
    exp_pix = '{sof: (p == 0), eol: ((p % W) == W - 1), data: ~a};
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    acc_q.delete();
    exp_k = 0;
    tick(1);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_tests++; if (vaddr !== 16'hC000) begin n_fail++; $display("FAIL t1_por_vaddr: got %h exp %h", vaddr, 16'hC000); end
    n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL t1_por_valid: got %b exp 0", pix_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_por_busy: got %b exp 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1; pix_ready = 1'b0;
    tick(6);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_active: got %b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (vaddr !== 16'hC000) begin n_fail++; $display("FAIL t1_async_vaddr: got %h exp %h", vaddr, 16'hC000); end
    n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL t1_async_valid: got %b exp 0", pix_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_async_busy: got %b exp 0", busy); end
    n_tests++; if ({pix_data, pix_sof, pix_eol} !== 18'h0) begin n_fail++; $display("FAIL t1_async_head: got %h/%b/%b exp 0", pix_data, pix_sof, pix_eol); end
    #2 rst = 1'b0;
    enable = 1'b0;
    acc_q.delete();
    exp_k = 0;
    tick(1);
  endtask

  task automatic test_stream();
    int n, gaps, bad;
    hard_reset();
    enable = 1'b1; pix_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pix_valid && n < 20) begin n++; @(negedge clk); end
    n_tests++; if (n !== RL + 1) begin n_fail++; $display("FAIL t2_latency: got %0d exp %0d", n, RL + 1); end
    n_tests++; if ({pix_sof, pix_eol, pix_data} !== {1'b1, 1'b0, 16'h3FFF}) begin n_fail++; $display("FAIL t2_first: got %b/%b/%h exp 1/0/3fff", pix_sof, pix_eol, pix_data); end
    gaps = 0;
    repeat (60) begin @(negedge clk); if (!pix_valid) gaps++; end
    n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL t2_throughput: got %0d bubbles exp 0", gaps); end
    tick(1);
    n_tests++; if (acc_q.size() !== 61) begin n_fail++; $display("FAIL t2_count: got %0d exp 61", acc_q.size()); end
    bad = -1;
    foreach (acc_q[i]) if (bad < 0 && acc_q[i] !== exp_pix(exp_k + i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL t2_seq: pixel %0d got %h exp %h", exp_k + bad, acc_q[bad], exp_pix(exp_k + bad)); end
    exp_k += acc_q.size(); acc_q.delete();
  endtask

  task automatic test_backpressure();
    int bad;
    hard_reset();
    enable = 1'b1; pix_ready = 1'b0;
    tick(50);
    n_tests++; if (vaddr !== 16'hC008) begin n_fail++; $display("FAIL t3_vaddr_stall: got %h exp %h", vaddr, 16'hC008); end
    n_tests++; if ({pix_valid, pix_sof, pix_data} !== {1'b1, 1'b1, 16'h3FFF}) begin n_fail++; $display("FAIL t3_head: got %b/%b/%h exp 1/1/3fff", pix_valid, pix_sof, pix_data); end
    enable = 1'b0; pix_ready = 1'b1;
    tick(20);
    n_tests++; if (acc_q.size() !== DEPTH) begin n_fail++; $display("FAIL t3_held: got %0d exp %0d", acc_q.size(), DEPTH); end
    n_tests++; if ({busy, vaddr} !== {1'b0, 16'hC008}) begin n_fail++; $display("FAIL t3_idle: got busy=%b vaddr=%h exp 0/c008", busy, vaddr); end
    enable = 1'b1;
    tick(30);
    bad = -1;
    foreach (acc_q[i]) if (bad < 0 && acc_q[i] !== exp_pix(exp_k + i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL t3_seq: pixel %0d got %h exp %h", exp_k + bad, acc_q[bad], exp_pix(exp_k + bad)); end
    exp_k += acc_q.size(); acc_q.delete();
  endtask

  task automatic test_freeze();
    logic [36:0] snap;
    int qn, changed, bad;
    enable = 1'b1; pix_ready = 1'b1;
    tick(5);
    gwe = 1'b0;
    snap = {vaddr, pix_data, pix_valid, pix_sof, pix_eol, busy};
    qn = acc_q.size();
    n_tests++; if ({pix_valid, pix_data} !== {1'b1, exp_pix(exp_k + qn).data}) begin n_fail++; $display("FAIL t5_head: got %b/%h exp 1/%h", pix_valid, pix_data, exp_pix(exp_k + qn).data); end
    changed = 0;
    repeat (10) begin
      @(negedge clk);
      if ({vaddr, pix_data, pix_valid, pix_sof, pix_eol, busy} !== snap) changed++;
    end
    tick(1);
    n_tests++; if (changed !== 0) begin n_fail++; $display("FAIL t5_frozen: got %0d changed cycles exp 0", changed); end
    n_tests++; if (acc_q.size() !== qn) begin n_fail++; $display("FAIL t5_no_pop: got %0d pixels exp %0d", acc_q.size(), qn); end
    gwe = 1'b1;
    tick(30);
    bad = -1;
    foreach (acc_q[i]) if (bad < 0 && acc_q[i] !== exp_pix(exp_k + i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL t5_seq: pixel %0d got %h exp %h", exp_k + bad, acc_q[bad], exp_pix(exp_k + bad)); end
    exp_k += acc_q.size(); acc_q.delete();
  endtask

  task automatic test_wrap();
    int cyc, first_bad, eol_cnt;
    pix_t got_bad, exp_bad, e, wrap_pix, row0_end;
    hard_reset();
    addr_oob = 1'b0;
    cyc = 0; first_bad = -1; eol_cnt = 0;
    got_bad = '0; exp_bad = '0; wrap_pix = '0; row0_end = '0;
    while (exp_k < FRAME + 300 && cyc < 60000) begin
      enable    = ($urandom_range(0, 4) != 0);
      pix_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      cyc++;
      foreach (acc_q[i]) begin
        e = exp_pix(exp_k + i);
        if (first_bad < 0 && acc_q[i] !== e) begin first_bad = exp_k + i; got_bad = acc_q[i]; exp_bad = e; end
        if (exp_k + i < FRAME && acc_q[i].eol) eol_cnt++;
        if (exp_k + i == FRAME) wrap_pix = acc_q[i];
        if (exp_k + i == W - 1) row0_end = acc_q[i];
      end
      exp_k += acc_q.size(); acc_q.delete();
    end
    n_tests++; if (exp_k < FRAME + 300) begin n_fail++; $display("FAIL t4_timeout: got %0d pixels exp >= %0d", exp_k, FRAME + 300); end
    n_tests++; if (first_bad >= 0) begin n_fail++; $display("FAIL t4_seq: pixel %0d got %h exp %h", first_bad, got_bad, exp_bad); end
    n_tests++; if (eol_cnt !== H) begin n_fail++; $display("FAIL t4_eol_count: got %0d exp %0d", eol_cnt, H); end
    n_tests++; if (row0_end !== {1'b0, 1'b1, 16'h3F80}) begin n_fail++; $display("FAIL t4_row_end: got %h exp %h", row0_end, {1'b0, 1'b1, 16'h3F80}); end
    n_tests++; if (wrap_pix !== {1'b1, 1'b0, 16'h3FFF}) begin n_fail++; $display("FAIL t4_frame_wrap: got %h exp %h", wrap_pix, {1'b1, 1'b0, 16'h3FFF}); end
    n_tests++; if (addr_oob !== 1'b0) begin n_fail++; $display("FAIL t4_vaddr_range: got out-of-frame vaddr exp none"); end
  endtask

  task automatic test_reset_inflight();
    int bad;
    pix_t first;
    hard_reset();
    enable = 1'b1; pix_ready = 1'b1;
    tick(20);
    bad = -1;
    foreach (acc_q[i]) if (bad < 0 && acc_q[i] !== exp_pix(exp_k + i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL t6_pre_seq: pixel %0d got %h exp %h", exp_k + bad, acc_q[bad], exp_pix(exp_k + bad)); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy_pre: got %b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({pix_valid, busy, vaddr} !== {1'b0, 1'b0, 16'hC000}) begin n_fail++; $display("FAIL t6_async: got %b/%b/%h exp 0/0/c000", pix_valid, busy, vaddr); end
    #2 rst = 1'b0;
    acc_q.delete();
    exp_k = 0;
    tick(30);
    first = (acc_q.size() > 0) ? acc_q[0] : '0;
    n_tests++; if (first !== {1'b1, 1'b0, 16'h3FFF}) begin n_fail++; $display("FAIL t6_first: got %h exp %h", first, {1'b1, 1'b0, 16'h3FFF}); end
    bad = -1;
    foreach (acc_q[i]) if (bad < 0 && acc_q[i] !== exp_pix(exp_k + i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL t6_seq: pixel %0d got %h exp %h", exp_k + bad, acc_q[bad], exp_pix(exp_k + bad)); end
    exp_k += acc_q.size(); acc_q.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_wrap();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
